// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a blocking I-mem read handshake,
// buffers a response IF/ID cannot accept and discards responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic [1:0]      pcmux_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic            IFID_en,
  output logic [XLEN-1:0] imem_address,
  output logic            imem_read,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  output logic            fetch_resp,
  output logic [XLEN-1:0] pc_if,
  output logic [XLEN-1:0] instr_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_buf;
  logic [XLEN-1:0] r_buf_pc;
  logic            r_buf_valid;
  logic [XLEN-1:0] r_stale_addr;

  logic [XLEN-1:0] w_next_pc;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic            w_stale_load;

  // Selector value 3 falls back to sequential fetch.
  always_comb begin
    case (pcmux_sel)
      2'd1:    w_next_pc = alu_out;
      2'd2:    w_next_pc = {alu_out[XLEN-1:1], 1'b0};
      default: w_next_pc = r_pc + XLEN'(4);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    imem_read    = 1'b0;
    imem_address = r_pc;
    fetch_resp   = 1'b0;
    pc_if        = r_pc;
    instr_if     = '0;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    w_stale_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        imem_read  = 1'b1;
        fetch_resp = imem_resp;
        instr_if   = imem_rdata;
        if (imem_resp) begin
          // A redirect in the same cycle makes the returned word useless to buffer.
          if (!IFID_en && !pc_en) begin
            w_buf_load   = 1'b1;
            w_state_next = HOLD;
          end
        end else if (pc_en) begin
          w_stale_load = 1'b1;
          w_state_next = KILL;
        end
      end
      HOLD: begin
        fetch_resp = r_buf_valid;
        instr_if   = r_buf;
        pc_if      = r_buf_pc;
        if (IFID_en || pc_en) begin
          w_buf_clear  = 1'b1;
          w_state_next = FETCH;
        end
      end
      KILL: begin
        // Keep the abandoned request's address stable until the memory answers.
        imem_read    = 1'b1;
        imem_address = r_stale_addr;
        if (imem_resp) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC[XLEN-1:0];
      r_buf_valid  <= 1'b0;
      r_stale_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (pc_en && (r_state != IDLE)) begin
        r_pc <= w_next_pc;
      end
      if (w_buf_load) begin
        r_buf_valid <= 1'b1;
      end else if (w_buf_clear) begin
        r_buf_valid <= 1'b0;
      end
      if (w_stale_load) begin
        r_stale_addr <= r_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_load) begin
      r_buf    <= imem_rdata;
      r_buf_pc <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/hold, mid-miss redirect,
// jalr alignment, redirect-over-buffer, PC wrap and reset during a killed request.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0060;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic [1:0]  pcmux_sel;
  logic [31:0] alu_out;
  logic        IFID_en;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        fetch_resp;
  logic [31:0] pc_if;
  logic [31:0] instr_if;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_en        (pc_en),
    .pcmux_sel    (pcmux_sel),
    .alu_out      (alu_out),
    .IFID_en      (IFID_en),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .fetch_resp   (fetch_resp),
    .pc_if        (pc_if),
    .instr_if     (instr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge; outputs are sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    pc_en      = 1'b0;
    pcmux_sel  = 2'd0;
    alu_out    = '0;
    IFID_en    = 1'b0;
    imem_rdata = '0;
    imem_resp  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (imem_read !== 1'b0) begin
        errors++;
        $display("FAIL reset_read cyc%0d: got %b want 0", i, imem_read);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_read !== 1'b0 || fetch_resp !== 1'b0 || imem_address !== RST_PC || instr_if !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs: read=%b resp=%b addr=%h instr=%h want 0 0 %h 0",
               imem_read, fetch_resp, imem_address, instr_if, RST_PC);
    end
    tick();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== RST_PC) begin
      errors++;
      $display("FAIL first_fetch: read=%b addr=%h want 1 %h", imem_read, imem_address, RST_PC);
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_streaming;
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_addr   = RST_PC + 32'(4 * i);
      imem_resp  = 1'b1;
      imem_rdata = 32'h0000_1000 + 32'(i);
      IFID_en    = 1'b1;
      pc_en      = 1'b1;
      pcmux_sel  = 2'd0;
      #1;
      checks++;
      if (imem_read !== 1'b1 || imem_address !== exp_addr || fetch_resp !== 1'b1 ||
          instr_if !== imem_rdata || pc_if !== exp_addr) begin
        errors++;
        $display("FAIL stream%0d: read=%b addr=%h resp=%b instr=%h pc_if=%h want 1 %h 1 %h %h",
                 i, imem_read, imem_address, fetch_resp, instr_if, pc_if, exp_addr, imem_rdata, exp_addr);
      end
      tick();
    end
    idle_inputs();
    $display("test_streaming done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall;
    do_reset();
    imem_resp = 1'b1; imem_rdata = 32'h1111_0060; IFID_en = 1'b1; pc_en = 1'b1;
    tick();
    imem_resp = 1'b1; imem_rdata = 32'hAAAA_0064; IFID_en = 1'b0; pc_en = 1'b0;
    #1;
    checks++;
    if (fetch_resp !== 1'b1 || instr_if !== 32'hAAAA_0064 || imem_address !== 32'h4000_0064) begin
      errors++;
      $display("FAIL stall_resp: resp=%b instr=%h addr=%h want 1 aaaa0064 40000064",
               fetch_resp, instr_if, imem_address);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      // A stray response while holding must not disturb the buffered word.
      imem_resp  = (i == 1);
      imem_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      checks++;
      if (imem_read !== 1'b0 || fetch_resp !== 1'b1 || instr_if !== 32'hAAAA_0064 ||
          pc_if !== 32'h4000_0064) begin
        errors++;
        $display("FAIL hold%0d: read=%b resp=%b instr=%h pc_if=%h want 0 1 aaaa0064 40000064",
                 i, imem_read, fetch_resp, instr_if, pc_if);
      end
      tick();
    end
    imem_resp = 1'b0; IFID_en = 1'b1; pc_en = 1'b1; pcmux_sel = 2'd0;
    #1;
    checks++;
    if (fetch_resp !== 1'b1 || imem_read !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: resp=%b read=%b want 1 0", fetch_resp, imem_read);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'h4000_0068) begin
      errors++;
      $display("FAIL after_hold: read=%b addr=%h want 1 40000068", imem_read, imem_address);
    end
    $display("test_stall done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_miss;
    do_reset();
    pc_en = 1'b1; pcmux_sel = 2'd1; alu_out = 32'h4000_1000;
    #1;
    checks++;
    if (imem_address !== RST_PC || imem_read !== 1'b1) begin
      errors++;
      $display("FAIL miss_issue: addr=%h read=%b want %h 1", imem_address, imem_read, RST_PC);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_address !== RST_PC || imem_read !== 1'b1 || fetch_resp !== 1'b0) begin
      errors++;
      $display("FAIL kill_hold_addr: addr=%h read=%b resp=%b want %h 1 0",
               imem_address, imem_read, fetch_resp, RST_PC);
    end
    tick();
    imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (fetch_resp !== 1'b0 || imem_address !== RST_PC) begin
      errors++;
      $display("FAIL kill_drop: resp=%b addr=%h want 0 %h", fetch_resp, imem_address, RST_PC);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'h4000_1000) begin
      errors++;
      $display("FAIL redirect_fetch: read=%b addr=%h want 1 40001000", imem_read, imem_address);
    end
    $display("test_mid_miss done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_jalr_and_wrap;
    // Continues from FETCH at 0x4000_1000.
    imem_resp = 1'b1; imem_rdata = 32'h0000_0067; IFID_en = 1'b1;
    pc_en = 1'b1; pcmux_sel = 2'd2; alu_out = 32'h4000_2003;
    #1;
    checks++;
    if (fetch_resp !== 1'b1 || pc_if !== 32'h4000_1000) begin
      errors++;
      $display("FAIL jalr_resp: resp=%b pc_if=%h want 1 40001000", fetch_resp, pc_if);
    end
    tick();
    pcmux_sel = 2'd3;
    #1;
    checks++;
    if (imem_address !== 32'h4000_2002) begin
      errors++;
      $display("FAIL jalr_target: addr=%h want 40002002", imem_address);
    end
    tick();
    #1;
    checks++;
    if (imem_address !== 32'h4000_2006) begin
      errors++;
      $display("FAIL sel3_plus4: addr=%h want 40002006", imem_address);
    end
    // Redirect on a stalled response: no buffering, keep fetching at the target.
    IFID_en = 1'b0; pcmux_sel = 2'd1; alu_out = 32'hFFFF_FFFC;
    tick();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL redirect_over_buf: read=%b addr=%h want 1 fffffffc", imem_read, imem_address);
    end
    IFID_en = 1'b1; pcmux_sel = 2'd0;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: read=%b addr=%h want 1 00000000", imem_read, imem_address);
    end
    $display("test_jalr_and_wrap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_kill;
    do_reset();
    pc_en = 1'b1; pcmux_sel = 2'd1; alu_out = 32'h4000_3000;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== RST_PC) begin
      errors++;
      $display("FAIL in_kill: read=%b addr=%h want 1 %h", imem_read, imem_address, RST_PC);
    end
    rst_n = 1'b0;
    tick();
    #1;
    checks++;
    if (imem_read !== 1'b0 || fetch_resp !== 1'b0) begin
      errors++;
      $display("FAIL kill_reset: read=%b resp=%b want 0 0", imem_read, fetch_resp);
    end
    rst_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (fetch_resp !== 1'b0 || instr_if !== 32'h0) begin
      errors++;
      $display("FAIL idle_ignore_resp: resp=%b instr=%h want 0 0", fetch_resp, instr_if);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_address !== RST_PC || fetch_resp !== 1'b0) begin
      errors++;
      $display("FAIL refetch_after_kill_reset: read=%b addr=%h resp=%b want 1 %h 0",
               imem_read, imem_address, fetch_resp, RST_PC);
    end
    $display("test_reset_kill done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    test_mid_miss();
    test_jalr_and_wrap();
    test_reset_kill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
